// File: rtl/lap_controller.sv
// Lap-memory and display controller: captures split times from the live BCD
// count and selects live or stored laps for the seven-segment display.
module lap_controller #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 5
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       lap,
  input  logic                       recall,
  input  logic                       clear,
  input  logic                       running,
  input  logic                       tick,
  input  logic [7:0]                 live_num,
  output logic [7:0]                 disp_num,
  output logic                       recall_mode,
  output logic [$clog2(DEPTH)-1:0]   lap_idx,
  output logic [$clog2(DEPTH):0]     lap_count,
  output logic                       full,
  output logic                       overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {LIVE, RECALL} state_t;

  state_t        state_q, state_d;
  logic [7:0]    disp_q, disp_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          mem_we;
  logic [7:0]    mem_q [DEPTH];
  logic          full_w;

  assign full_w = (cnt_q == CW'(DEPTH));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    tick_d  = tick_q;
    mem_we  = 1'b0;
    disp_d  = live_num;
    if (clear) begin
      state_d = LIVE;
      idx_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      tick_d  = '0;
    end else begin
      case (state_q)
        LIVE: begin
          if (recall && cnt_q != '0) begin
            state_d = RECALL;
            idx_d   = '0;
            tick_d  = '0;
          end else if (lap && running) begin
            if (full_w) begin
              ovf_d = 1'b1;
            end else begin
              mem_we = 1'b1;
              cnt_d  = cnt_q + CW'(1);
            end
          end
        end
        RECALL: begin
          if (recall) begin
            if (CW'(idx_q) + CW'(1) < cnt_q) begin
              idx_d  = idx_q + IW'(1);
              tick_d = '0;
            end else begin
              state_d = LIVE;
              idx_d   = '0;
              tick_d  = '0;
            end
          end else if (tick) begin
            if (tick_q == TW'(TIMEOUT - 1)) begin
              state_d = LIVE;
              idx_d   = '0;
              tick_d  = '0;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        default: state_d = LIVE;
      endcase
    end
    // Display follows the slot selected for the coming cycle, so a recall
    // press shows its lap on the same edge that samples it.
    if (state_d == RECALL) disp_d = mem_q[idx_d];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= LIVE;
      disp_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tick_q  <= tick_d;
    end
  end

  // Lap storage holds no reset; lap_count alone defines which slots are valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cnt_q[IW-1:0]] <= live_num;
  end

  assign disp_num    = disp_q;
  assign recall_mode = (state_q == RECALL);
  assign lap_idx     = idx_q;
  assign lap_count   = cnt_q;
  assign full        = full_w;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_lap_controller.sv
// Self-checking bench for lap_controller: vector table with scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_lap_controller;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       lap = 1'b0, recall = 1'b0, clear = 1'b0, running = 1'b0, tick = 1'b0;
  logic [7:0] live_num = 8'h00;
  logic [7:0] disp_num;
  logic       recall_mode;
  logic [1:0] lap_idx;
  logic [2:0] lap_count;
  logic       full, overflow;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  lap_controller #(.DEPTH(4), .TIMEOUT(5)) dut (
    .clk(clk), .n_rst(n_rst), .lap(lap), .recall(recall), .clear(clear),
    .running(running), .tick(tick), .live_num(live_num), .disp_num(disp_num),
    .recall_mode(recall_mode), .lap_idx(lap_idx), .lap_count(lap_count),
    .full(full), .overflow(overflow)
  );

  typedef struct packed {
    logic       lap, rec, clr, run, tk;
    logic [7:0] live;
    logic       dc;     // disp_num not compared on this step
    logic [7:0] disp;
    logic       mode;
    logic [1:0] idx;
    logic [2:0] cnt;
    logic       full, ovf;
  } vec_t;

  typedef struct packed {
    logic        dc;
    logic [15:0] outs;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  function automatic vec_t v(input logic l, r, c, ru, t, input logic [7:0] live,
                             input logic dc, input logic [7:0] disp, input logic mode,
                             input logic [1:0] idx, input logic [2:0] cnt,
                             input logic f, o);
    vec_t x;
    x.lap = l; x.rec = r; x.clr = c; x.run = ru; x.tk = t; x.live = live;
    x.dc = dc; x.disp = disp; x.mode = mode; x.idx = idx; x.cnt = cnt;
    x.full = f; x.ovf = o;
    return x;
  endfunction

  function automatic logic [15:0] outs_now();
    return {disp_num, recall_mode, lap_idx, lap_count, full, overflow};
  endfunction

  task automatic check(input string name, input exp_t e);
    logic [15:0] act, req;
    act = outs_now();
    req = e.outs;
    if (e.dc) begin
      act[15:8] = 8'h00;
      req[15:8] = 8'h00;
    end
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got disp=%h mode=%b idx=%0d cnt=%0d full=%b ovf=%b, expected disp=%h mode=%b idx=%0d cnt=%0d full=%b ovf=%b",
               name, act[15:8], act[7], act[6:5], act[4:2], act[1], act[0],
               req[15:8], req[7], req[6:5], req[4:2], req[1], req[0]);
    end else begin
      $display("ok   %s: disp=%h mode=%b idx=%0d cnt=%0d full=%b ovf=%b",
               name, act[15:8], act[7], act[6:5], act[4:2], act[1], act[0]);
    end
  endtask

  task automatic apply(input vec_t x, input string name);
    exp_t e;
    @(negedge clk);
    lap = x.lap; recall = x.rec; clear = x.clr; running = x.run; tick = x.tk;
    live_num = x.live;
    e.dc = x.dc;
    e.outs = {x.disp, x.mode, x.idx, x.cnt, x.full, x.ovf};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name, sb.pop_front());
    lap = 1'b0; recall = 1'b0; clear = 1'b0; tick = 1'b0;
  endtask

  initial begin
    exp_t e0;
    //                 lap rec clr run tk live   dc disp  md idx cnt f o
    vq.push_back(v(1, 0, 0, 1, 0, 8'h07, 0, 8'h07, 0, 0, 3'd1, 0, 0)); // lap 07
    vq.push_back(v(1, 0, 0, 1, 0, 8'h12, 0, 8'h12, 0, 0, 3'd2, 0, 0)); // lap 12
    vq.push_back(v(1, 0, 0, 1, 0, 8'h25, 0, 8'h25, 0, 0, 3'd3, 0, 0)); // lap 25
    vq.push_back(v(0, 1, 0, 1, 0, 8'h30, 0, 8'h07, 1, 0, 3'd3, 0, 0)); // recall enter
    vq.push_back(v(0, 1, 0, 1, 0, 8'h30, 0, 8'h12, 1, 1, 3'd3, 0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 8'h30, 0, 8'h25, 1, 2, 3'd3, 0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 8'h31, 1, 8'h00, 0, 0, 3'd3, 0, 0)); // past last -> LIVE
    vq.push_back(v(0, 0, 0, 1, 0, 8'h32, 0, 8'h32, 0, 0, 3'd3, 0, 0)); // live follows
    vq.push_back(v(1, 0, 0, 1, 0, 8'h40, 0, 8'h40, 0, 0, 3'd4, 1, 0)); // fill
    vq.push_back(v(1, 0, 0, 1, 0, 8'h41, 0, 8'h41, 0, 0, 3'd4, 1, 1)); // overflow
    vq.push_back(v(0, 0, 1, 1, 0, 8'h42, 1, 8'h00, 0, 0, 3'd0, 0, 0)); // clear
    vq.push_back(v(0, 0, 0, 1, 0, 8'h43, 0, 8'h43, 0, 0, 3'd0, 0, 0));
    vq.push_back(v(1, 0, 0, 0, 0, 8'h44, 0, 8'h44, 0, 0, 3'd0, 0, 0)); // paused lap ignored
    vq.push_back(v(0, 1, 0, 0, 0, 8'h45, 0, 8'h45, 0, 0, 3'd0, 0, 0)); // recall, empty
    vq.push_back(v(1, 0, 0, 1, 0, 8'h50, 0, 8'h50, 0, 0, 3'd1, 0, 0));
    vq.push_back(v(1, 0, 0, 1, 0, 8'h51, 0, 8'h51, 0, 0, 3'd2, 0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 8'h52, 0, 8'h50, 1, 0, 3'd2, 0, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(v(0, 0, 0, 1, 1, 8'h53, 0, 8'h50, 1, 0, 3'd2, 0, 0)); // 4 ticks stay
    vq.push_back(v(0, 1, 0, 1, 0, 8'h54, 0, 8'h51, 1, 1, 3'd2, 0, 0)); // advance, restart
    for (int i = 0; i < 4; i++)
      vq.push_back(v(0, 0, 0, 1, 1, 8'h55, 0, 8'h51, 1, 1, 3'd2, 0, 0));
    vq.push_back(v(0, 0, 0, 1, 1, 8'h56, 1, 8'h00, 0, 0, 3'd2, 0, 0)); // 5th tick -> LIVE
    vq.push_back(v(1, 1, 0, 1, 0, 8'h60, 0, 8'h50, 1, 0, 3'd2, 0, 0)); // lap+recall
    vq.push_back(v(0, 1, 1, 1, 0, 8'h61, 1, 8'h00, 0, 0, 3'd0, 0, 0)); // clear+recall
    vq.push_back(v(1, 0, 0, 1, 0, 8'h70, 0, 8'h70, 0, 0, 3'd1, 0, 0));
    vq.push_back(v(1, 0, 0, 1, 0, 8'h71, 0, 8'h71, 0, 0, 3'd2, 0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 8'h72, 0, 8'h70, 1, 0, 3'd2, 0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 8'h73, 0, 8'h71, 1, 1, 3'd2, 0, 0));

    #2;
    e0.dc = 1'b0;
    e0.outs = 16'h0000;
    check("reset_state", e0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      apply(vq[i], $sformatf("vec%0d", i));

    // Recall mode with lap_idx = 1 held; reset must clear outputs before any edge.
    #2;
    n_rst = 1'b0;
    #1;
    check("async_reset", e0);
    #10;
    n_rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lap_controller.md
# lap_controller

Lap-memory and display controller for the stopwatch. It sits between the BCD counter output and the seven-segment decoder. It captures split times from the live count into a small buffer on lap presses and decides what the display shows: the live count, or stored laps stepped through on recall presses. Every button input is a one-cycle pulse from the existing synchronizer/edge-detect stage.

## Interface
- DEPTH, 4: number of lap slots; power of two, at least 2.
- TIMEOUT, 5: number of tick pulses with no recall press before recall mode returns to live.
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  reset; asynchronous and active-low.
- lap  input  1  one-cycle pulse; capture the live count.
- recall  input  1  one-cycle pulse; enter recall mode or advance to the next lap.
- clear  input  1  one-cycle pulse; empty the buffer and return to live.
- running  input  1  level; high while the stopwatch counts (from the FSM).
- tick  input  1  one-cycle pulse, 1 Hz, free-running (independent of pause).
- live_num  input  8  live BCD count, tens[7:4] and ones[3:0].
- disp_num  output  8  BCD value sent to the decoder; registered.
- recall_mode  output  1  high while in RECALL.
- lap_idx  output  clog2(DEPTH)  slot currently displayed in RECALL; 0 in LIVE.
- lap_count  output  clog2(DEPTH)+1  number of stored laps, 0..DEPTH.
- full  output  1  high when lap_count == DEPTH.
- overflow  output  1  sticky; a lap was dropped because the buffer was full.

## Operation
- Two states: LIVE and RECALL.
- Storage: DEPTH x 8-bit register array with write pointer = lap_count. Laps fill slot 0 upward; the buffer never wraps or overwrites.
- Priority in any one cycle: clear, then recall, then lap.
- clear (any state):
  - lap_count = 0, overflow = 0, lap_idx = 0, tick counter = 0; state goes to LIVE.
  - Memory contents need not be zeroed.
- LIVE:
  - disp_num <= live_num every cycle.
  - lap with running = 1 and not full: mem[lap_count] <= live_num, then lap_count increments.
  - lap with running = 1 and full: the lap is dropped and overflow <= 1.
  - lap with running = 0: ignored; no store, no overflow.
  - recall with lap_count > 0: go to RECALL with lap_idx = 0, disp_num <= mem[0], tick counter = 0. A lap pulse in the same cycle is dropped.
  - recall with lap_count == 0: ignored; stay in LIVE.
- RECALL:
  - disp_num <= mem[lap_idx].
  - recall: if lap_idx + 1 < lap_count, lap_idx increments and the tick counter resets to 0. Otherwise (past the last lap) go to LIVE with lap_idx = 0.
  - tick: the tick counter increments. When the counter equals TIMEOUT-1 and a tick arrives, go to LIVE with lap_idx = 0.
  - lap: ignored, including overflow.
  - running is irrelevant; the count keeps advancing underneath.
- Arithmetic: lap_count and lap_idx are plain binary. Stored values are copied bit-exact, with no BCD adjustment.

## Timing
- Reset (n_rst low, asynchronous):
  - state LIVE; disp_num, lap_idx, lap_count, tick counter all 0.
  - full, overflow, recall_mode all 0.
- Reset mid-RECALL returns to LIVE immediately and discards all laps.
- Every output is registered and updates on the edge that samples the event. There is no combinational path from input to output.
- In LIVE, disp_num lags live_num by exactly one cycle.
- A lap sampled at edge k stores the value live_num has at edge k. lap_count and full reflect it after edge k.
- A recall at edge k: recall_mode and disp_num = mem[0] are valid after edge k.
- Timeout: exactly TIMEOUT tick pulses after entry or after the last recall press; LIVE is visible after the edge that samples the final tick.
- A clear coincident with any other input: only the clear takes effect.

## Test plan
- Reset, then running = 1: with live_num = 0x07, 0x12, 0x25, pulse lap at each -> lap_count = 3, full = 0. Then recall x3 -> disp_num 0x07, 0x12, 0x25; the 4th recall -> LIVE, disp_num follows live_num one cycle later.
- Fill DEPTH = 4 laps, then one more lap -> full = 1, overflow = 1, lap_count stays 4. clear -> lap_count = 0, full = 0, overflow = 0.
- running = 0, lap pulse -> nothing stored. recall with 0 laps -> recall_mode stays 0.
- Two laps stored, recall, then 4 ticks -> still RECALL. Recall press (lap_idx = 1), then 5 ticks -> LIVE on the 5th tick's edge.
- Same-cycle events: lap + recall in LIVE -> RECALL entered, lap_count unchanged. clear + recall in RECALL -> LIVE, lap_count = 0.
- Assert n_rst while in RECALL with lap_idx = 1 -> all outputs 0 immediately, without waiting for a clock edge.
